cpu_step_ctrl: RTL and testbench

- Consumer end of the clock divider: turns the free-running clkdiv bus into single-cycle CPU clock-enable pulses on the main clk, so the CPU has no derived clock.
- Modes: free run (fast or slow tap, chosen by SW2), or single-step from a debounced push button.
- Also keeps a wrapping count of issued enables for the seven-segment display.
- Sits between clk_div and the CPU core / display mux.

---
 rtl/cpu_clk_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 108 ++++++++++
 rtl/cpu_step_ctrl.sv | 103 ++++++++++
 tb/tb_cpu_step_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_clk_pkg
// Purpose : Shared debounce FSM encoding and default clkdiv tap positions.
// Rev     : 1.0
// ============================================================================
package cpu_clk_pkg;

    typedef logic [1:0] dbn_state_t;

    localparam dbn_state_t S_IDLE         = 2'd0;
    localparam dbn_state_t S_PRESS_WAIT   = 2'd1;
    localparam dbn_state_t S_PRESSED      = 2'd2;
    localparam dbn_state_t S_RELEASE_WAIT = 2'd3;

    localparam int unsigned C_DEF_FAST_BIT = 2;
    localparam int unsigned C_DEF_SLOW_BIT = 16;

    function automatic logic rising(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : Two-flop synchronizer plus press/release debounce FSM for a button.
// Rev     : 1.0
// ============================================================================
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             w_btn_s;
    dbn_state_t       state_q;
    dbn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_cnt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign w_btn_s    = sync_q[1];
    assign w_cnt_done = (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both wait states require an unbroken run of the new level; any glitch
    // returns to the previous settled state without touching the output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_btn_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_btn_s) begin
                    state_d = S_IDLE;
                end else if (w_cnt_done) begin
                    state_d = S_PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!w_btn_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_btn_s) begin
                    state_d = S_PRESSED;
                end else if (w_cnt_done) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_o = 1'b0;
        press_o = 1'b0;
        case (state_q)
            S_PRESS_WAIT:              press_o = w_btn_s & w_cnt_done;
            S_PRESSED, S_RELEASE_WAIT: level_o = 1'b1;
            default: begin
                level_o = 1'b0;
                press_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_ctrl
// Purpose : Turns clkdiv taps or debounced button presses into CPU clock enables.
// Rev     : 1.0
// ============================================================================
module cpu_step_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned FAST_BIT        = C_DEF_FAST_BIT,
    parameter int unsigned SLOW_BIT        = C_DEF_SLOW_BIT,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clkdiv_i,
    input  logic        sw2_i,
    input  logic        run_sw_i,
    input  logic        step_btn_i,
    input  logic        halt_i,
    output logic        cpu_ce_o,
    output logic [31:0] ce_count_o,
    output logic        btn_level_o
);

    logic [1:0]  sw2_sync_q;
    logic [1:0]  run_sync_q;
    logic        w_sw2_s;
    logic        w_run_s;
    logic        w_sel;
    logic        sel_q;
    logic        w_tick;
    logic        w_step_req;
    logic        cpu_ce_d;
    logic        cpu_ce_q;
    logic [31:0] ce_count_q;
    logic        w_unused_clkdiv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw2_sync_q <= 2'b00;
            run_sync_q <= 2'b00;
        end else begin
            sw2_sync_q <= {sw2_sync_q[0], sw2_i};
            run_sync_q <= {run_sync_q[0], run_sw_i};
        end
    end

    assign w_sw2_s = sw2_sync_q[1];
    assign w_run_s = run_sync_q[1];

    // clkdiv shares this clock domain, so its taps are used without syncing.
    assign w_sel  = w_sw2_s ? clkdiv_i[SLOW_BIT] : clkdiv_i[FAST_BIT];
    assign w_tick = rising(w_sel, sel_q);

    assign w_unused_clkdiv = ^clkdiv_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= w_sel;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_step_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (step_btn_i),
        .level_o (btn_level_o),
        .press_o (w_step_req)
    );

    // Step mode deliberately ignores halt so the user can step past it;
    // a press seen in run mode is simply dropped.
    always_comb begin
        cpu_ce_d = 1'b0;
        if (w_run_s) begin
            cpu_ce_d = w_tick & ~halt_i;
        end else begin
            cpu_ce_d = w_step_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ce_q   <= 1'b0;
            ce_count_q <= 32'd0;
        end else begin
            cpu_ce_q   <= cpu_ce_d;
            ce_count_q <= ce_count_q + {31'd0, cpu_ce_q};
        end
    end

    assign cpu_ce_o   = cpu_ce_q;
    assign ce_count_o = ce_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_step_ctrl
// Purpose : Scoreboard bench for cpu_step_ctrl with a free-running clkdiv.
// Rev     : 1.0
// ============================================================================
module tb_cpu_step_ctrl;

    localparam int unsigned DEB = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] clkdiv   = 32'd0;
    logic        sw2      = 1'b0;
    logic        run_sw   = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt     = 1'b0;
    logic        cpu_ce;
    logic [31:0] ce_count;
    logic        btn_level;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc          = 0;
    int          n_checks     = 0;
    int          n_fail       = 0;
    logic [31:0] exp_count    = 32'd0;
    logic [31:0] c0           = 32'd0;
    logic [31:0] preload_val  = 32'd0;
    int          preload_seq  = 0;
    int          preload_seen = 0;
    logic        m_sel_q = 1'b0;
    logic        run_h1  = 1'b0;
    logic        run_h2  = 1'b0;
    logic        sw_h1   = 1'b0;
    logic        sw_h2   = 1'b0;

    cpu_step_ctrl #(
        .FAST_BIT        (2),
        .SLOW_BIT        (16),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clkdiv_i    (clkdiv),
        .sw2_i       (sw2),
        .run_sw_i    (run_sw),
        .step_btn_i  (step_btn),
        .halt_i      (halt),
        .cpu_ce_o    (cpu_ce),
        .ce_count_o  (ce_count),
        .btn_level_o (btn_level)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (preload_seq != preload_seen) begin
                clkdiv       = preload_val;
                preload_seen = preload_seq;
            end else begin
                clkdiv = clkdiv + 32'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every cpu_ce pulse must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (cpu_ce === 1'b1) begin
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_ce: cycle %0d cpu_ce=1, expected no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || ce_count !== e.cnt) begin
                        n_fail = n_fail + 1;
                        $display("FAIL ce_pulse: got cycle %0d count 0x%08h, expected cycle %0d count 0x%08h",
                                 cyc, ce_count, e.cyc, e.cnt);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL missed_ce: cycle %0d cpu_ce=%b, expected pulse at cycle %0d",
                         cyc, cpu_ce, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int c);
        exp_q.push_back('{cyc: c, cnt: exp_count});
        exp_count = exp_count + 32'd1;
    endtask

    // Predicts run-mode pulses for the coming edge, then advances one clock.
    task automatic cycle();
        logic [31:0] vn;
        logic        sel;
        if (!rst_n) begin
            m_sel_q = 1'b0;
            run_h1  = 1'b0;
            run_h2  = 1'b0;
            sw_h1   = 1'b0;
            sw_h2   = 1'b0;
        end else begin
            vn  = (preload_seq != preload_seen) ? preload_val : clkdiv + 32'd1;
            sel = sw_h2 ? vn[16] : vn[2];
            if (run_h2 && sel && !m_sel_q && !halt) push_exp(cyc + 1);
            m_sel_q = sel;
            run_h2  = run_h1;
            run_h1  = run_sw;
            sw_h2   = sw_h1;
            sw_h1   = sw2;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    // Raw button high from the next edge n; pulse and level expected at n+DEB+2.
    task automatic press(input int hold, input bit expect_pulse);
        int n;
        step_btn = 1'b1;
        n        = cyc + 1;
        if (expect_pulse) push_exp(n + int'(DEB) + 2);
        for (int i = 0; i < hold; i++) begin
            cycle();
            if (cyc == n + int'(DEB) + 1) check("btn_level_before", {31'd0, btn_level}, 32'd0);
            if (cyc == n + int'(DEB) + 2) check("btn_level_after", {31'd0, btn_level}, 32'd1);
        end
    endtask

    initial begin
        @(posedge clk);
        #2;
        check("reset_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("reset_ce_count", ce_count, 32'd0);
        check("reset_btn_level", {31'd0, btn_level}, 32'd0);
        cycles(3);
        rst_n = 1'b1;

        // Fast run: bit 2 rises every 8 clocks.
        run_sw = 1'b1;
        cycles(6);
        c0 = ce_count;
        cycles(64);
        check("run_fast_count", ce_count - c0, 32'd8);

        // Asynchronous reset mid-stream.
        cycles(3);
        rst_n = 1'b0;
        exp_q.delete();
        exp_count = 32'd0;
        #1;
        check("midreset_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        check("midreset_ce_count", ce_count, 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(24);

        // Halt freezes pulses and the count.
        halt = 1'b1;
        cycles(2);
        c0 = ce_count;
        cycles(30);
        check("halt_frozen", ce_count - c0, 32'd0);
        halt = 1'b0;
        c0   = ce_count;
        cycles(17);
        check("halt_resume", ce_count - c0, 32'd2);

        // Slow tap: bit 16 rises once when clkdiv crosses 0x10000.
        sw2 = 1'b1;
        cycles(4);
        preload_val = 32'h0000_FFF0;
        preload_seq = preload_seq + 1;
        c0 = ce_count;
        cycles(40);
        check("run_slow_count", ce_count - c0, 32'd1);
        sw2 = 1'b0;
        cycles(8);

        // Step with bounce.
        run_sw = 1'b0;
        cycles(4);
        c0 = ce_count;
        step_btn = 1'b1;
        cycle();
        step_btn = 1'b0;
        cycle();
        press(10, 1'b1);
        step_btn = 1'b0;
        cycles(10);
        check("step_level_off", {31'd0, btn_level}, 32'd0);
        check("step_count", ce_count - c0, 32'd1);

        // Long hold, short glitch release, then a real re-press.
        c0 = ce_count;
        press(100, 1'b1);
        step_btn = 1'b0;
        cycles(2);
        step_btn = 1'b1;
        cycles(20);
        check("glitch_level_held", {31'd0, btn_level}, 32'd1);
        step_btn = 1'b0;
        cycles(10);
        press(20, 1'b1);
        step_btn = 1'b0;
        cycles(10);
        check("repress_count", ce_count - c0, 32'd2);

        // Wrap, stepping while halt is high.
        halt = 1'b1;
        force dut.ce_count_q = 32'hFFFF_FFFF;
        cycle();
        release dut.ce_count_q;
        exp_count = 32'hFFFF_FFFF;
        press(10, 1'b1);
        step_btn = 1'b0;
        cycles(10);
        check("wrap_count", ce_count, 32'd0);

        // Press in run mode (halted), then switch to step: nothing issued.
        run_sw = 1'b1;
        cycles(4);
        c0 = ce_count;
        press(12, 1'b0);
        check("run_press_level", {31'd0, btn_level}, 32'd1);
        run_sw = 1'b0;
        cycles(10);
        step_btn = 1'b0;
        cycles(10);
        halt = 1'b0;
        cycles(4);
        check("mode_switch_count", ce_count - c0, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
